casr_stream_checker: RTL and testbench

- Receiving end of the 32-bit CASR pseudo-random generator (rule-90 cells, one rule-150 cell at bit 21, null boundaries).
- Takes the generated word stream, self-synchronises to it, and predicts each following word locally.
- Flags and counts mismatches.
- Sits on the far side of any link or datapath under BIST, so pattern integrity can be checked in hardware.

---
 rtl/casr_pkg.sv | 28 ++
 rtl/casr_step.sv | 11 +
 rtl/casr_stream_checker.sv | 163 ++++++++++++++++
 tb/tb_casr_stream_checker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/casr_pkg.sv
// Shared CASR definitions: 32-cell rule-90 automaton with a rule-150 cell at bit 21.
// Used by both the pattern generator and the stream checker.
package casr_pkg;

   localparam int          CASR_W       = 32;
   localparam logic [31:0] RULE150_MASK = 32'h0020_0000;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } chk_state_t;

   // Null boundaries: the shifted-in zeros model s[-1] = s[32] = 0.
   function automatic logic [CASR_W-1:0] casr_next(input logic [CASR_W-1:0] s);
      return {s[CASR_W-2:0], 1'b0} ^ {1'b0, s[CASR_W-1:1]} ^ (s & RULE150_MASK);
   endfunction

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) begin
         n = n + 6'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/casr_step.sv
// Combinational CASR next-state function f(s).
module casr_step
   import casr_pkg::*;
(
   input  logic [CASR_W-1:0] s,
   output logic [CASR_W-1:0] f
);

   assign f = casr_next(s);

endmodule

// File: rtl/casr_stream_checker.sv
// Self-synchronising CASR stream checker: HUNT -> VERIFY -> LOCKED with flywheel prediction.
// Define CASR_CHK_BITERR_EN to add the pipelined bit_err_count output.
module casr_stream_checker
   import casr_pkg::*;
#(
   parameter int LOCK_COUNT = 4,
   parameter int LOSS_COUNT = 3,
   parameter int ERR_CNT_W  = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [CASR_W-1:0]    in_data,
   input  logic                 clear_counts,
   output logic                 locked,
   output logic                 err_pulse,
`ifdef CASR_CHK_BITERR_EN
   output logic [31:0]          bit_err_count,
`endif
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [3:0] LOCK_TGT = 4'(LOCK_COUNT);
   localparam logic [3:0] LOSS_TGT = 4'(LOSS_COUNT);

   chk_state_t             state_q, state_d;
   logic [CASR_W-1:0]      expected_q, expected_d;
   logic [3:0]             match_cnt_q, match_cnt_d;
   logic [3:0]             miss_cnt_q, miss_cnt_d;
   logic                   locked_q, locked_d;
   logic                   err_pulse_q, err_pulse_d;
   logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
   logic [CASR_W-1:0]      f_in, f_exp;
   logic                   is_match, count_err;
   logic [3:0]             match_inc, miss_inc;

   casr_step u_step_in  (.s(in_data),    .f(f_in));
   casr_step u_step_exp (.s(expected_q), .f(f_exp));

   assign is_match  = (in_data == expected_q);
   assign match_inc = match_cnt_q + 4'd1;
   assign miss_inc  = miss_cnt_q + 4'd1;

   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      count_err   = 1'b0;
      if (in_valid) begin
         case (state_q)
            HUNT: begin
               // All-zero is a fixed point of f and can never seed a stream.
               if (in_data != '0) begin
                  expected_d  = f_in;
                  match_cnt_d = '0;
                  state_d     = VERIFY;
               end
            end
            VERIFY: begin
               expected_d = f_in;
               if (is_match) begin
                  match_cnt_d = match_inc;
                  if (match_inc == LOCK_TGT) begin
                     state_d    = LOCKED;
                     miss_cnt_d = '0;
                  end
               end else begin
                  match_cnt_d = '0;
                  if (in_data == '0) begin
                     state_d = HUNT;
                  end
               end
            end
            LOCKED: begin
               // Flywheel: predict from our own expectation, never from received data.
               expected_d = f_exp;
               if (is_match) begin
                  miss_cnt_d = '0;
               end else begin
                  count_err  = 1'b1;
                  miss_cnt_d = miss_inc;
                  if (miss_inc == LOSS_TGT) begin
                     state_d = HUNT;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_comb begin
      locked_d    = (state_d == LOCKED);
      err_pulse_d = count_err;
      err_count_d = err_count_q;
      if (clear_counts) begin
         err_count_d = count_err ? ERR_CNT_W'(1) : '0;
      end else if (count_err && (err_count_q != '1)) begin
         err_count_d = err_count_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= HUNT;
         expected_q  <= '0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

`ifdef CASR_CHK_BITERR_EN
   logic [CASR_W-1:0] diff_q, diff_d;
   logic [31:0]       bit_err_q, bit_err_d;
   logic [5:0]        diff_pop;
   logic [32:0]       bit_sum;

   assign diff_pop = popcount32(diff_q);
   assign bit_sum  = {1'b0, bit_err_q} + 33'(diff_pop);

   // Stage 1 captures the error pattern, stage 2 accumulates its popcount.
   always_comb begin
      diff_d    = count_err ? (in_data ^ expected_q) : '0;
      bit_err_d = bit_err_q;
      if (clear_counts) begin
         bit_err_d = 32'(diff_pop);
      end else if (bit_sum[32]) begin
         bit_err_d = '1;
      end else begin
         bit_err_d = bit_sum[31:0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         diff_q    <= '0;
         bit_err_q <= '0;
      end else begin
         diff_q    <= diff_d;
         bit_err_q <= bit_err_d;
      end
   end

   assign bit_err_count = bit_err_q;
`endif

endmodule

// File: tb/tb_casr_stream_checker.sv
// Testbench for casr_stream_checker: step-function vector table plus scoreboarded stream sequences.
module tb_casr_stream_checker;

   localparam int LOCK_COUNT = 4;
   localparam int LOSS_COUNT = 3;
   localparam int ERR_CNT_W  = 4;

   logic                 clock = 1'b0;
   logic                 reset = 1'b0;
   logic                 in_valid = 1'b0;
   logic [31:0]          in_data = '0;
   logic                 clear_counts = 1'b0;
   logic                 locked, err_pulse;
   logic [ERR_CNT_W-1:0] err_count;
`ifdef CASR_CHK_BITERR_EN
   logic [31:0]          bit_err_count;
`endif
   logic [31:0]          step_in, step_out;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   casr_stream_checker #(
      .LOCK_COUNT(LOCK_COUNT),
      .LOSS_COUNT(LOSS_COUNT),
      .ERR_CNT_W (ERR_CNT_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .clear_counts (clear_counts),
      .locked       (locked),
      .err_pulse    (err_pulse),
`ifdef CASR_CHK_BITERR_EN
      .bit_err_count(bit_err_count),
`endif
      .err_count    (err_count)
   );

   casr_step u_step (.s(step_in), .f(step_out));

   typedef struct {
      logic                 l;
      logic                 p;
      logic [ERR_CNT_W-1:0] c;
      logic [31:0]          b;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic [31:0] din;
      logic [31:0] dout;
   } step_vec_t;
   step_vec_t vecs[4];

   int                   m_state;
   logic [31:0]          m_exp;
   int                   m_match, m_miss, m_pend;
   logic                 m_locked, m_pulse;
   logic [ERR_CNT_W-1:0] m_cnt;
   logic [31:0]          m_bits;
   logic [31:0]          g;

   function automatic logic [31:0] ref_next(input logic [31:0] s);
      logic [31:0] n;
      logic l, r;
      for (int i = 0; i < 32; i++) begin
         l = (i > 0)  ? s[i-1] : 1'b0;
         r = (i < 31) ? s[i+1] : 1'b0;
         n[i] = l ^ r ^ ((i == 21) ? s[i] : 1'b0);
      end
      return n;
   endfunction

   function automatic int ref_pop(input logic [31:0] v);
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_exp = '0; m_match = 0; m_miss = 0; m_pend = 0;
      m_locked = 0; m_pulse = 0; m_cnt = '0; m_bits = '0;
      sb_q.delete();
   endtask

   task automatic model_step(input logic v, input logic [31:0] d, input logic clr);
      logic        err;
      logic [31:0] e0;
      logic [32:0] s;
      err = 1'b0;
      e0  = m_exp;
      if (v) begin
         case (m_state)
            0: if (d != 0) begin m_exp = ref_next(d); m_match = 0; m_state = 1; end
            1: begin
               m_exp = ref_next(d);
               if (d == e0) begin
                  m_match++;
                  if (m_match == LOCK_COUNT) begin m_state = 2; m_miss = 0; end
               end else begin
                  m_match = 0;
                  if (d == 0) m_state = 0;
               end
            end
            default: begin
               m_exp = ref_next(e0);
               if (d == e0) m_miss = 0;
               else begin
                  err = 1'b1;
                  m_miss++;
                  if (m_miss == LOSS_COUNT) m_state = 0;
               end
            end
         endcase
      end
      if (clr) m_bits = 32'(m_pend);
      else begin
         s = {1'b0, m_bits} + 33'(m_pend);
         m_bits = s[32] ? '1 : s[31:0];
      end
      m_pend = err ? ref_pop(d ^ e0) : 0;
      if (clr) m_cnt = err ? ERR_CNT_W'(1) : '0;
      else if (err && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      m_pulse  = err;
      m_locked = (m_state == 2);
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic clr);
      exp_t e;
      in_valid = v; in_data = d; clear_counts = clr;
      model_step(v, d, clr);
      e.l = m_locked; e.p = m_pulse; e.c = m_cnt; e.b = m_bits;
      sb_q.push_back(e);
      @(posedge clock); #1;
      e = sb_q.pop_front();
      $display("txn v=%0b d=%h clr=%0b -> locked=%0b pulse=%0b cnt=%0d", v, d, clr, locked, err_pulse, err_count);
      check("sb_locked", 32'(locked), 32'(e.l));
      check("sb_pulse", 32'(err_pulse), 32'(e.p));
      check("sb_count", 32'(err_count), 32'(e.c));
`ifdef CASR_CHK_BITERR_EN
      check("sb_bits", bit_err_count, e.b);
`endif
      in_valid = 1'b0; clear_counts = 1'b0;
   endtask

   task automatic send_good();
      drive(1'b1, g, 1'b0);
      g = ref_next(g);
   endtask

   task automatic send_bad(input logic [31:0] mask, input logic clr);
      drive(1'b1, g ^ mask, clr);
      g = ref_next(g);
   endtask

   task automatic acquire(input string tag);
      for (int k = 0; k < 5; k++) begin
         send_good();
         if (k == 3) check({tag, "_not_yet"}, 32'(locked), 32'd0);
      end
      check({tag, "_locked"}, 32'(locked), 32'd1);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0001, 32'h0000_0002};
      vecs[1] = '{32'h0000_0002, 32'h0000_0005};
      vecs[2] = '{32'h0020_0000, 32'h0070_0000};
      vecs[3] = '{32'h8000_0000, 32'h4000_0000};
      model_reset();
      step_in = '0;

      repeat (2) @(posedge clock);
      #1;
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_pulse", 32'(err_pulse), 32'd0);
      check("rst_count", 32'(err_count), 32'd0);
      reset = 1'b1;

      for (int i = 0; i < 4; i++) begin
         step_in = vecs[i].din;
         #1;
         $display("step in=%h out=%h", step_in, step_out);
         check("step", step_out, vecs[i].dout);
      end

      g = 32'h0000_0001;
      acquire("acq");
      check("acq_count", 32'(err_count), 32'd0);

      send_bad(32'h0000_0080, 1'b0);
      check("single_pulse", 32'(err_pulse), 32'd1);
      check("single_count", 32'(err_count), 32'd1);
      check("single_locked", 32'(locked), 32'd1);
      repeat (3) send_good();
      check("flywheel_pulse", 32'(err_pulse), 32'd0);
      check("flywheel_count", 32'(err_count), 32'd1);

      repeat (4) drive(1'b0, $urandom, 1'b0);
      check("bubble_locked", 32'(locked), 32'd1);
      repeat (2) send_good();
      check("bubble_count", 32'(err_count), 32'd1);

      drive(1'b0, '0, 1'b1);
      check("clear_count", 32'(err_count), 32'd0);
      send_bad(32'h0000_0080, 1'b0);
      send_bad(32'h0001_0000, 1'b0);
      check("loss_still_locked", 32'(locked), 32'd1);
      send_bad(32'h0000_0003, 1'b0);
      check("loss_locked", 32'(locked), 32'd0);
      check("loss_count", 32'(err_count), 32'd3);
      acquire("relock");

      reset = 1'b0;
      model_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      repeat (5) drive(1'b1, '0, 1'b0);
      check("zero_hunt", 32'(locked), 32'd0);
      g = 32'h1234_5678;
      acquire("zero_acq");

      for (int r = 0; r < 8; r++) begin
         send_bad(32'h0000_0100, 1'b0);
         send_bad(32'h0000_0100, 1'b0);
         send_good();
      end
      check("sat_count", 32'(err_count), 32'(ERR_CNT_W'('1)));
      check("sat_locked", 32'(locked), 32'd1);

      send_bad(32'h0000_0001, 1'b1);
      check("clear_with_err", 32'(err_count), 32'd1);
      send_good();

`ifdef CASR_CHK_BITERR_EN
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b0);
      check("bits_cleared", bit_err_count, 32'd0);
      send_bad(32'h0001_0005, 1'b0);
      check("bits_lag", bit_err_count, 32'd0);
      drive(1'b0, '0, 1'b0);
      check("bits_three", bit_err_count, 32'd3);
`endif

      send_good();
      #2;
      reset = 1'b0;
      #1;
      check("async_locked", 32'(locked), 32'd0);
      check("async_count", 32'(err_count), 32'd0);
      check("async_pulse", 32'(err_pulse), 32'd0);
      model_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      acquire("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
